uart_frame_rcvr: RTL and testbench
==================================

# uart_frame_rcvr

Parametrised serial frame receiver: second generation of the project's oversampled UART receiver. It deserialises LSB-first frames of DATA_BITS data bits with optional parity and one or two stop bits from UART_RX. Each bit is decided by a 3-sample majority vote, and errors are reported on dedicated flags. Received words go to the downstream consumer through a valid/ready output register with overrun detection.

## Interface
- DATA_BITS, 128: data bits per frame, 1..255.
- OVERSAMPLE, 16: sample_en ticks per bit, 8..64.
- PARITY_EN, 1: 1 = parity bit present after data.
- PARITY_ODD, 1: 1 = odd parity (data+parity has an odd number of ones); 0 = even. Ignored if PARITY_EN = 0.
- STOP_BITS, 1: 1 or 2.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_en  in  1  oversample tick; tie high to sample every clock.
- UART_RX  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  last accepted word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts; transfer when data_valid && data_ready.
- parity_err  out  1  1-cycle pulse: frame dropped on parity mismatch.
- frame_err  out  1  1-cycle pulse: frame dropped, a stop bit sampled low.
- overrun  out  1  1-cycle pulse: good frame dropped because data_valid was still high.
- busy  out  1  FSM not in IDLE.

## Operation
- UART_RX passes through a 2-flop synchroniser every clock. rx_s is the second flop. All decisions use rx_s.
- The tick counter, sample shift and FSM advance only on cycles with sample_en = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s = 0 on a tick -> START, tick counter cleared to 0.
- Voting: samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit. The bit value is the majority of the three, decided at tick OVERSAMPLE/2+1. The counter wraps at OVERSAMPLE-1.
- START: vote = 1 -> IDLE (glitch rejected, no flag). Vote = 0 -> DATA.
- DATA: shift the vote into the MSB of the shift register and update the running parity. After DATA_BITS bits -> PARITY if PARITY_EN, else STOP.
- PARITY: compare the vote with the expected parity bit and latch the mismatch.
- STOP: any stop vote = 0 -> frame_err pulse -> BREAK. After the last stop vote = 1:
  - parity mismatch -> parity_err pulse, word dropped;
  - else data_valid = 1 and consumer has not accepted this cycle -> overrun pulse; the old word is kept and the new one dropped;
  - else the word loads into data_out and data_valid is set.
  - In every case -> IDLE.
- BREAK: wait for rx_s = 1 on a tick -> IDLE. This prevents a held-low line re-triggering starts.
- data_valid clears the cycle after the handshake. A load is allowed in the same cycle the consumer accepts.
- Only one error flag pulses per frame. Stop-bit failure takes priority over a latched parity mismatch.

## Timing
- Reset values: data_out = 0, data_valid = 0, all error flags = 0, busy = 0, FSM = IDLE, synchroniser flops = 1.
- Reset mid-frame aborts the frame. No flag or data results.
- Latency from the UART_RX edge to rx_s is 2 clocks.
- data_valid and flags are registered. They assert the clock after the final stop-bit vote tick.
- The final stop vote falls at tick OVERSAMPLE/2+1 of the last stop bit. IDLE is re-entered there, so a following start edge half a bit later is caught.
- sample_en = 0 freezes all receive state. The handshake and data_valid clearing still operate every clock.
- Parity and the bit counter are sized from parameters: bit counter width clog2(DATA_BITS+1), tick counter width clog2(OVERSAMPLE).

## Structure
- Package uart_rcvr_pkg holds the FSM state encoding and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) shared with the planned transmitter.
- One sub-module, rcvr_sample_vote, contains the synchroniser, the 3-sample shift and majority logic, and outputs rx_s and vote.
- The FSM, counters and output register live in the top module.

## Test plan
- Defaults, sample_en = 1, data_ready = 1: send 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with correct odd parity -> one data_valid, data_out equals the word, no flags.
- Pulse UART_RX low for 5 clocks (< OVERSAMPLE/2) -> no frame, busy returns to 0, no flags.
- Wrong parity bit -> parity_err pulses once, data_valid stays 0. Stop bit held low for 3 bit times -> one frame_err, BREAK until the line rises, then the next frame is received correctly.
- data_ready = 0, send two good frames -> first word held, overrun pulses once after the second. Raise data_ready -> first word transferred.
- DATA_BITS = 8, PARITY_EN = 0, STOP_BITS = 2, sample_en every 4th clock: send 8'hA5 -> data_out = 8'hA5. Flip one of the three votes of each bit -> same result.
- Assert reset mid-DATA -> outputs at reset values next cycle, the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rcvr_pkg.sv
// Shared constants for the UART receiver family: FSM state encoding,
// parity-mode codes (also used by the planned transmitter) and a helper
// that produces the parity bit for a given data XOR.
package uart_rcvr_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   // Parity bit that makes data+parity even (PAR_EVEN) or odd (PAR_ODD).
   function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
      return (mode == PAR_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/rcvr_sample_vote.sv
// Front end of the UART receiver: two-flop synchroniser for the raw line
// and a two-deep sample history that, together with the live synchronised
// value, forms a 3-sample majority vote.
module rcvr_sample_vote (
   input  logic clock,
   input  logic reset,
   input  logic sample,
   input  logic uart_rx,
   output logic rx_s,
   output logic vote
);

   logic       sync1_q, sync1_d;
   logic       rx_s_q, rx_s_d;
   logic [1:0] samp_q, samp_d;

   // Synchroniser runs every clock; the sample history only moves on sample strobes.
   always_comb begin
      sync1_d = uart_rx;
      rx_s_d  = sync1_q;
      samp_d  = samp_q;
      if (sample) begin
         samp_d = {samp_q[0], rx_s_q};
      end
   end

   // Line idles high, so the synchroniser and history reset to 1.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         samp_q  <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         rx_s_q  <= rx_s_d;
         samp_q  <= samp_d;
      end
   end

   assign rx_s = rx_s_q;
   assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

endmodule

// File: rtl/uart_frame_rcvr.sv
// Oversampled UART frame receiver: LSB-first data, optional parity, one or
// two stop bits, majority-voted bits, error pulses and a valid/ready output
// register that drops new words while an old one is still unconsumed.
module uart_frame_rcvr
   import uart_rcvr_pkg::*;
#(
   parameter int DATA_BITS  = 128,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sample_en,
   input  logic                 UART_RX,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [1:0]        PAR_MODE  = (PARITY_EN == 0) ? PAR_NONE :
                                             (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   logic [2:0]           state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 par_bad_q, par_bad_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   logic rx_s;
   logic vote;
   logic in_bit;
   logic sample;
   logic frame_done;
   logic frame_fail;

   assign in_bit = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_PARITY) || (state_q == ST_STOP);
   assign sample = sample_en && in_bit && ((tick_q == TICK_S0) || (tick_q == TICK_S1));

   rcvr_sample_vote u_vote (
      .clock   (clock),
      .reset   (reset),
      .sample  (sample),
      .uart_rx (UART_RX),
      .rx_s    (rx_s),
      .vote    (vote)
   );

   // Receive FSM: counts ticks within each bit and acts on the mid-bit vote.
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      par_bad_d  = par_bad_q;
      stop_d     = stop_q;
      frame_done = 1'b0;
      frame_fail = 1'b0;
      if (sample_en) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
               tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
               if (tick_q == TICK_VOTE) begin
                  case (state_q)
                     ST_START: begin
                        if (vote) begin
                           state_d = ST_IDLE;
                        end else begin
                           state_d   = ST_DATA;
                           bit_d     = '0;
                           par_d     = 1'b0;
                           par_bad_d = 1'b0;
                           stop_d    = 1'b0;
                        end
                     end
                     ST_DATA: begin
                        shift_d                = shift_q >> 1;
                        shift_d[DATA_BITS-1]   = vote;
                        par_d                  = par_q ^ vote;
                        bit_d                  = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                           state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                     end
                     ST_PARITY: begin
                        par_bad_d = (vote != parity_bit(PAR_MODE, par_q));
                        state_d   = ST_STOP;
                     end
                     ST_STOP: begin
                        if (!vote) begin
                           frame_fail = 1'b1;
                           state_d    = ST_BREAK;
                        end else if (stop_q == STOP_LAST) begin
                           frame_done = 1'b1;
                           state_d    = ST_IDLE;
                        end else begin
                           stop_d = 1'b1;
                        end
                     end
                     default: begin
                        state_d = ST_IDLE;
                     end
                  endcase
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output register: handshake every clock, frame results only at frame end.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
      if (frame_fail) begin
         ferr_d = 1'b1;
      end else if (frame_done) begin
         if (par_bad_q) begin
            perr_d = 1'b1;
         end else if (valid_q && !data_ready) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end
   end

   // Receive state registers; reset aborts any frame in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         par_bad_q <= 1'b0;
         stop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         par_bad_q <= par_bad_d;
         stop_q    <= stop_d;
      end
   end

   // Output and flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rcvr.sv
// Bench for uart_frame_rcvr: a default 128-bit instance (a) fed one bit per
// 16 clocks, and an 8-bit, no-parity, two-stop-bit instance (b) ticked every
// 4th clock. Each frame sent queues the outcome the frame rules predict; a
// negedge monitor matches every observed word/flag against those queues.
module tb_uart_frame_rcvr;

   localparam int EV_WORD = 0;
   localparam int EV_PAR  = 1;
   localparam int EV_FRM  = 2;
   localparam int EV_OVR  = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset_a, sample_en_a, rx_a, ready_a;
   logic         valid_a, perr_a, ferr_a, ovr_a, busy_a;
   logic [127:0] data_a;
   logic         reset_b, sample_en_b, rx_b, ready_b;
   logic         valid_b, perr_b, ferr_b, ovr_b, busy_b;
   logic [7:0]   data_b;

   int checks   = 0;
   int failures = 0;

   int           exp_kind_a[$];
   int           exp_kind_b[$];
   logic [127:0] exp_data_a[$];
   logic [127:0] exp_data_b[$];
   logic         held_a = 1'b0;

   uart_frame_rcvr dut_a (
      .clock      (clock),
      .reset      (reset_a),
      .sample_en  (sample_en_a),
      .UART_RX    (rx_a),
      .data_out   (data_a),
      .data_valid (valid_a),
      .data_ready (ready_a),
      .parity_err (perr_a),
      .frame_err  (ferr_a),
      .overrun    (ovr_a),
      .busy       (busy_a)
   );

   uart_frame_rcvr #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16),
      .PARITY_EN  (0),
      .PARITY_ODD (0),
      .STOP_BITS  (2)
   ) dut_b (
      .clock      (clock),
      .reset      (reset_b),
      .sample_en  (sample_en_b),
      .UART_RX    (rx_b),
      .data_out   (data_b),
      .data_valid (valid_b),
      .data_ready (ready_b),
      .parity_err (perr_b),
      .frame_err  (ferr_b),
      .overrun    (ovr_b),
      .busy       (busy_b)
   );

   task automatic waitClk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkEq(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic pushExp(input int idx, input int kind, input logic [127:0] d);
      if (idx == 0) begin
         exp_kind_a.push_back(kind);
         exp_data_a.push_back(d);
      end else begin
         exp_kind_b.push_back(kind);
         exp_data_b.push_back(d);
      end
   endtask

   task automatic consumeEvent(input int idx, input int kind, input logic [127:0] data);
      int           k;
      logic [127:0] d;
      bit           empty;
      checks++;
      empty = (idx == 0) ? (exp_kind_a.size() == 0) : (exp_kind_b.size() == 0);
      if (empty) begin
         failures++;
         $display("[TB] FAIL event_dut%0d: got kind %0d data %h, required no event", idx, kind, data);
      end else begin
         if (idx == 0) begin
            k = exp_kind_a.pop_front();
            d = exp_data_a.pop_front();
         end else begin
            k = exp_kind_b.pop_front();
            d = exp_data_b.pop_front();
         end
         if (k != kind || (kind == EV_WORD && d !== data)) begin
            failures++;
            $display("[TB] FAIL event_dut%0d: got kind %0d data %h, required kind %0d data %h",
                     idx, kind, data, k, d);
         end
      end
   endtask

   // Compares one instance's outputs for the cycle just completed.
   task automatic checkOutput(input int idx, input logic valid, input logic [127:0] data,
                              input logic perr, input logic ferr, input logic ovr,
                              input logic pv, input logic pr, input logic prst,
                              input logic [127:0] pd);
      if (!prst && pv && !pr) begin
         checks++;
         if (valid !== 1'b1 || data !== pd) begin
            failures++;
            $display("[TB] FAIL hold_dut%0d: got valid=%b data=%h, required valid=1 data=%h",
                     idx, valid, data, pd);
         end
      end
      if (valid === 1'b1 && (!pv || pr) && !prst) consumeEvent(idx, EV_WORD, data);
      if (perr === 1'b1) consumeEvent(idx, EV_PAR, '0);
      if (ferr === 1'b1) consumeEvent(idx, EV_FRM, '0);
      if (ovr === 1'b1)  consumeEvent(idx, EV_OVR, '0);
   endtask

   logic         pv_a = 1'b0, pr_a = 1'b0, prst_a = 1'b1;
   logic         pv_b = 1'b0, pr_b = 1'b0, prst_b = 1'b1;
   logic [127:0] pd_a = '0, pd_b = '0;

   // Monitor: every cycle, away from the active edge.
   always @(negedge clock) begin
      checkOutput(0, valid_a, data_a, perr_a, ferr_a, ovr_a, pv_a, pr_a, prst_a, pd_a);
      checkOutput(1, valid_b, {120'b0, data_b}, perr_b, ferr_b, ovr_b, pv_b, pr_b, prst_b, pd_b);
      pv_a = valid_a; pr_a = ready_a; prst_a = reset_a; pd_a = data_a;
      pv_b = valid_b; pr_b = ready_b; prst_b = reset_b; pd_b = {120'b0, data_b};
   end

   task automatic bitA(input logic v);
      rx_a = v;
      waitClk(16);
   endtask

   // Sends one frame to instance a and queues the outcome the frame rules predict.
   task automatic applyStimulus(input logic [127:0] word, input logic bad_par, input int stop_low_bits);
      if (stop_low_bits > 0) begin
         pushExp(0, EV_FRM, '0);
      end else if (bad_par) begin
         pushExp(0, EV_PAR, '0);
      end else if (held_a && !ready_a) begin
         pushExp(0, EV_OVR, '0);
      end else begin
         pushExp(0, EV_WORD, word);
         held_a = !ready_a;
      end
      bitA(1'b0);
      for (int i = 0; i < 128; i++) bitA(word[i]);
      bitA((~^word) ^ bad_par);
      if (stop_low_bits > 0) begin
         rx_a = 1'b0;
         waitClk(16 * stop_low_bits);
         checkEq("busy_in_break", {127'b0, busy_a}, 128'd1);
      end
      bitA(1'b1);
      waitClk(32);
   endtask

   // One sample period of instance b: line set, then a single sample_en tick.
   task automatic slotB(input logic v);
      rx_b        = v;
      sample_en_b = 1'b0;
      waitClk(3);
      sample_en_b = 1'b1;
      waitClk(1);
      sample_en_b = 1'b0;
   endtask

   // Frame for instance b, 16 slots per bit; samples land on slots 8, 9, 10.
   task automatic sendFrameB(input logic [7:0] word, input logic flip);
      logic [10:0] fb;
      logic        v;
      fb = {2'b11, word, 1'b0};
      pushExp(1, EV_WORD, {120'b0, word});
      for (int k = 0; k < 11; k++) begin
         for (int s = 0; s < 16; s++) begin
            v = fb[k];
            if (flip && s == 8 + (k % 3)) v = ~v;
            slotB(v);
         end
      end
      for (int s = 0; s < 16; s++) slotB(1'b1);
   endtask

   initial begin
      reset_a = 1'b1; sample_en_a = 1'b1; rx_a = 1'b1; ready_a = 1'b1;
      reset_b = 1'b1; sample_en_b = 1'b0; rx_b = 1'b1; ready_b = 1'b1;
      waitClk(3);
      reset_a = 1'b0;
      reset_b = 1'b0;
      waitClk(1);
      $display("[TB] reset values");
      checkEq("a_reset_data", data_a, '0);
      checkEq("a_reset_ctl", {123'b0, valid_a, busy_a, perr_a, ferr_a, ovr_a}, '0);
      checkEq("b_reset_data", {120'b0, data_b}, '0);
      checkEq("b_reset_ctl", {123'b0, valid_b, busy_b, perr_b, ferr_b, ovr_b}, '0);

      $display("[TB] good frame, odd parity");
      applyStimulus(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 0);
      checkEq("a_word0", data_a, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      checkEq("a_word0_taken", {127'b0, valid_a}, '0);

      $display("[TB] start glitch");
      rx_a = 1'b0;
      waitClk(5);
      checkEq("busy_in_glitch", {127'b0, busy_a}, 128'd1);
      rx_a = 1'b1;
      waitClk(48);
      checkEq("busy_after_glitch", {127'b0, busy_a}, '0);

      $display("[TB] parity error");
      applyStimulus(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b1, 0);
      checkEq("a_par_dropped", data_a, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

      $display("[TB] stop held low, then recovery");
      applyStimulus(128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_8765, 1'b1, 3);
      applyStimulus(128'hCAFE_F00D_0BAD_BEEF_8000_0000_0000_0001, 1'b0, 0);
      checkEq("a_after_break", data_a, 128'hCAFE_F00D_0BAD_BEEF_8000_0000_0000_0001);

      $display("[TB] overrun");
      ready_a = 1'b0;
      applyStimulus(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0);
      applyStimulus(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0, 0);
      checkEq("a_held_word", data_a, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      checkEq("a_held_valid", {127'b0, valid_a}, 128'd1);
      ready_a = 1'b1;
      held_a  = 1'b0;
      waitClk(2);
      checkEq("a_held_taken", {127'b0, valid_a}, '0);

      $display("[TB] reset mid-frame");
      rx_a = 1'b0;
      waitClk(16);
      for (int i = 0; i < 40; i++) bitA(i[0]);
      reset_a = 1'b1;
      waitClk(1);
      checkEq("a_midreset_data", data_a, '0);
      checkEq("a_midreset_ctl", {123'b0, valid_a, busy_a, perr_a, ferr_a, ovr_a}, '0);
      reset_a = 1'b0;
      rx_a    = 1'b1;
      waitClk(48);
      applyStimulus(128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0, 1'b0, 0);
      checkEq("a_after_reset", data_a, 128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0);

      $display("[TB] 8-bit instance, sparse ticks");
      sendFrameB(8'hA5, 1'b0);
      checkEq("b_word", {120'b0, data_b}, 128'hA5);
      reset_b = 1'b1;
      waitClk(1);
      reset_b = 1'b0;
      checkEq("b_cleared", {120'b0, data_b}, '0);
      waitClk(4);
      sendFrameB(8'hA5, 1'b1);
      checkEq("b_word_voted", {120'b0, data_b}, 128'hA5);

      checkEq("a_events_left", 128'(exp_kind_a.size()), '0);
      checkEq("b_events_left", 128'(exp_kind_b.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
